// File: rtl/knn_seq_ctrl_if.sv
// knn_seq_ctrl_if
//   Bundle of every signal between the kNN sequencer and its surroundings
//   (register file, point memory, insertion sorter, result consumer).
//   master : the sequencer (knn_seq_ctrl)
//   slave  : the environment driving start/n_pts, sorter_idx and res_ready
//   Signals:
//     start, n_pts          run request and training-point count
//     busy, done            run status
//     mem_rd_en, mem_addr   point-memory read (data returns one cycle later)
//     sorter_clr/ready/done/sel, sorter_idx   sorter control and read-back
//     res_idx/valid/ready/last                 result stream
interface knn_seq_ctrl_if #(
    parameter int K  = 4,
    parameter int AW = 8
);
    localparam int SW = (K > 1) ? $clog2(K) : 1;

    logic          start;
    logic [AW-1:0] n_pts;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic          sorter_clr;
    logic          sorter_ready;
    logic          sorter_done;
    logic [SW-1:0] sorter_sel;
    logic [AW-1:0] sorter_idx;
    logic [AW-1:0] res_idx;
    logic          res_valid;
    logic          res_ready;
    logic          res_last;

    modport master (
        input  start, n_pts, sorter_idx, res_ready,
        output busy, done, mem_rd_en, mem_addr, sorter_clr, sorter_ready,
               sorter_done, sorter_sel, res_idx, res_valid, res_last
    );

    modport slave (
        output start, n_pts, sorter_idx, res_ready,
        input  busy, done, mem_rd_en, mem_addr, sorter_clr, sorter_ready,
               sorter_done, sorter_sel, res_idx, res_valid, res_last
    );
endinterface

// File: rtl/knn_seq_ctrl.sv
// knn_seq_ctrl
//   Sequencer for the kNN insertion-sort datapath. Per run it clears the
//   sorter, streams n_pts training points from the point memory into the
//   sorter (one per cycle), then reads back the min(n_pts,K) nearest indices
//   and emits them on a valid/ready result stream.
//   Ports:
//     clk   clock
//     rst   synchronous active-high reset
//     bus   knn_seq_ctrl_if master modport (see interface header)
module knn_seq_ctrl #(
    parameter int K  = 4,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    knn_seq_ctrl_if.master bus
);
    localparam int SW = (K > 1) ? $clog2(K) : 1;

    localparam logic [AW-1:0] ONE_A = AW'(1);
    localparam logic [AW-1:0] K_A   = AW'(K);
    localparam logic [SW:0]   ONE_O = (SW+1)'(1);
    localparam logic [SW:0]   K_O   = (SW+1)'(K);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_OUT, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] addr_cnt;
    logic [AW-1:0] n_pts_r;
    logic [SW:0]   out_cnt;
    logic [SW:0]   n_out_r;
    logic [SW:0]   n_out_calc;
    logic          last_beat;
    logic          rd_en_p1;

    always_comb begin
        n_out_calc = (bus.n_pts < K_A) ? bus.n_pts[SW:0] : K_O;
    end

    assign last_beat = (out_cnt == n_out_r - ONE_O);

    // State register, counters and the memory-latency alignment register
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            addr_cnt <= '0;
            n_pts_r  <= '0;
            out_cnt  <= '0;
            n_out_r  <= '0;
            rd_en_p1 <= 1'b0;
        end else begin
            state    <= state_nxt;
            // sorter_ready follows the read strobe by the memory latency
            rd_en_p1 <= (state == S_RUN);
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        n_pts_r <= bus.n_pts;
                        n_out_r <= n_out_calc;
                        out_cnt <= '0;
                    end
                end
                S_CLEAR: addr_cnt <= '0;
                S_RUN:   addr_cnt <= addr_cnt + ONE_A;
                S_OUT: begin
                    if (bus.res_ready) out_cnt <= out_cnt + ONE_O;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.start) state_nxt = (bus.n_pts == '0) ? S_DONE : S_CLEAR;
            end
            S_CLEAR: state_nxt = S_RUN;
            S_RUN: begin
                if (addr_cnt == n_pts_r - ONE_A) state_nxt = S_DRAIN;
            end
            S_DRAIN: state_nxt = S_OUT;
            S_OUT: begin
                if (bus.res_ready && last_beat) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.busy         = (state != S_IDLE);
        bus.done         = (state == S_DONE);
        bus.mem_rd_en    = (state == S_RUN);
        bus.mem_addr     = (state == S_RUN) ? addr_cnt : '0;
        bus.sorter_clr   = (state == S_CLEAR);
        bus.sorter_ready = rd_en_p1;
        // index registers only update while points are still arriving
        bus.sorter_done  = !((state == S_RUN) || (state == S_DRAIN));
        bus.sorter_sel   = '0;
        bus.res_valid    = 1'b0;
        bus.res_idx      = '0;
        bus.res_last     = 1'b0;
        if (state == S_OUT) begin
            bus.sorter_sel = out_cnt[SW-1:0];
            bus.res_valid  = 1'b1;
            bus.res_idx    = bus.sorter_idx;
            bus.res_last   = last_beat;
        end
    end
endmodule

// File: tb/tb_knn_seq_ctrl.sv
// tb_knn_seq_ctrl
//   Self-checking bench for knn_seq_ctrl. Environment models: a point memory
//   with one cycle of read latency and an insertion sorter that reports the
//   sel-th nearest inserted index. Expected results come from sorting the
//   point distances directly.
module tb_knn_seq_ctrl;
    localparam int K  = 4;
    localparam int AW = 8;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    knn_seq_ctrl_if #(.K(K), .AW(AW)) bus ();
    knn_seq_ctrl #(.K(K), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    // ---------------- environment: point memory + sorter ----------------
    int unsigned   pdist [256];
    logic [AW-1:0] ins_idx [256];
    int            ins_n = 0;
    logic [AW-1:0] mq_addr;
    logic          mq_vld;

    always @(posedge clk) begin
        mq_addr <= bus.mem_addr;
        mq_vld  <= bus.mem_rd_en;
        if (rst || bus.sorter_clr) ins_n <= 0;
        else if (bus.sorter_ready && ins_n < 256) begin
            ins_idx[ins_n] <= mq_addr;
            ins_n          <= ins_n + 1;
        end
    end

    always_comb begin : sorter_model
        int rnk;
        rnk = 0;
        bus.sorter_idx = '0;
        for (int j = 0; j < ins_n; j++) begin
            rnk = 0;
            for (int m = 0; m < ins_n; m++)
                if (pdist[ins_idx[m]] < pdist[ins_idx[j]]) rnk++;
            if (rnk == int'(bus.sorter_sel)) bus.sorter_idx = ins_idx[j];
        end
    end

    // ---------------- run recorder ----------------
    int            r_done_cyc, r_rdy_first, r_rdy_last, r_rdy_cnt, r_rd_cnt;
    int            r_max_sel, r_misalign, r_last_cnt, r_last_pos, r_vld_cnt;
    int            r_stall_bad;
    logic [AW-1:0] r_beats [$];
    int            exp_q [$];

    task automatic gen_dists(input int n);
        bit dup;
        for (int i = 0; i < n; i++) begin
            do begin
                pdist[i] = $urandom_range(0, 65535);
                dup = 1'b0;
                for (int m = 0; m < i; m++) if (pdist[m] == pdist[i]) dup = 1'b1;
            end while (dup);
        end
    endtask

    // Expected result: indices of the min(n,K) smallest distances, nearest first
    task automatic build_exp(input int n);
        int idx [$];
        int best, tmp;
        exp_q.delete();
        for (int i = 0; i < n; i++) idx.push_back(i);
        for (int i = 0; i < n; i++) begin
            best = i;
            for (int m = i + 1; m < n; m++) if (pdist[idx[m]] < pdist[idx[best]]) best = m;
            tmp = idx[i]; idx[i] = idx[best]; idx[best] = tmp;
        end
        for (int i = 0; i < n && i < K; i++) exp_q.push_back(idx[i]);
    endtask

    function automatic int exp_done(input int n, input int sb, input int sl);
        int no;
        no = (n < K) ? n : K;
        if (n == 0) return 1;
        return n + 3 + no + ((sb >= 0 && sb < no) ? sl : 0);
    endfunction

    // Starts a run (start sampled in cycle 0) and records behaviour until done
    task automatic do_run(input int n, input int stall_beat, input int stall_len);
        int cyc, left;
        logic [AW-1:0] held_idx;
        logic [SW-1:0] held_sel;
        bit held_ok;
        r_done_cyc = -1; r_rdy_first = -1; r_rdy_last = -1; r_rdy_cnt = 0;
        r_rd_cnt = 0; r_max_sel = 0; r_misalign = 0; r_last_cnt = 0;
        r_last_pos = -1; r_vld_cnt = 0; r_stall_bad = 0;
        r_beats.delete();
        left = stall_len; held_ok = 1'b0; held_idx = '0; held_sel = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.n_pts = AW'(n); bus.res_ready = 1'b1;
        @(negedge clk);
        cyc = 1;
        forever begin
            // start/n_pts toggle freely while busy; they must be ignored
            bus.start = 1'($urandom_range(0, 1));
            bus.n_pts = AW'($urandom);
            bus.res_ready = 1'b1;
            if (bus.res_valid && r_beats.size() == stall_beat && left > 0) begin
                bus.res_ready = 1'b0;
                left--;
                if (!held_ok) begin
                    held_idx = bus.res_idx; held_sel = bus.sorter_sel; held_ok = 1'b1;
                end else if (bus.res_idx !== held_idx || bus.sorter_sel !== held_sel)
                    r_stall_bad++;
            end
            if (bus.sorter_ready) begin
                if (r_rdy_first < 0) r_rdy_first = cyc;
                r_rdy_last = cyc;
                r_rdy_cnt++;
            end
            if (mq_vld !== bus.sorter_ready) r_misalign++;
            if (bus.mem_rd_en) r_rd_cnt++;
            if (int'(bus.sorter_sel) > r_max_sel) r_max_sel = int'(bus.sorter_sel);
            if (bus.res_valid) r_vld_cnt++;
            if (bus.res_valid && bus.res_ready) begin
                r_beats.push_back(bus.res_idx);
                if (bus.res_last) begin r_last_cnt++; r_last_pos = r_beats.size() - 1; end
            end
            if (bus.done) begin
                r_done_cyc = cyc;
                bus.start = 1'b0;
                break;
            end
            cyc++;
            if (cyc > 3000) begin
                checks++; errors++;
                $display("FAIL run_timeout: no done within %0d cycles (n=%0d)", cyc, n);
                bus.start = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    function automatic bit beats_match();
        if (r_beats.size() != exp_q.size()) return 1'b0;
        foreach (exp_q[i]) if (int'(r_beats[i]) != exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b0; bus.n_pts = '0; bus.res_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid); end
        checks++; if (bus.sorter_ready !== 1'b0) begin errors++; $display("FAIL reset_sorter_ready: got %b want 0", bus.sorter_ready); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++; if (bus.mem_rd_en !== 1'b0 || bus.sorter_clr !== 1'b0) begin errors++; $display("FAIL reset_mem_clr: got rd_en=%b clr=%b want 0 0", bus.mem_rd_en, bus.sorter_clr); end
        checks++; if (bus.sorter_done !== 1'b1) begin errors++; $display("FAIL reset_sorter_done: got %b want 1", bus.sorter_done); end
    endtask

    task automatic test_vector6();
        int want [4] = '{1, 4, 3, 2};
        bit ok;
        pdist[0] = 50; pdist[1] = 10; pdist[2] = 40; pdist[3] = 30; pdist[4] = 20; pdist[5] = 60;
        do_run(6, -1, 0);
        checks++; if (r_rdy_first != 3 || r_rdy_last != 8 || r_rdy_cnt != 6) begin errors++; $display("FAIL vec6_ready: got first=%0d last=%0d cnt=%0d want 3 8 6", r_rdy_first, r_rdy_last, r_rdy_cnt); end
        ok = (r_beats.size() == 4);
        if (ok) foreach (want[i]) if (int'(r_beats[i]) != want[i]) ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL vec6_beats: got %0d beats %p want 1 4 3 2", r_beats.size(), r_beats); end
        checks++; if (r_last_cnt != 1 || r_last_pos != 3) begin errors++; $display("FAIL vec6_last: got cnt=%0d pos=%0d want 1 3", r_last_cnt, r_last_pos); end
        checks++; if (r_done_cyc != 13) begin errors++; $display("FAIL vec6_done: got cycle %0d want 13", r_done_cyc); end
        checks++; if (r_rd_cnt != 6 || r_misalign != 0) begin errors++; $display("FAIL vec6_mem: got reads=%0d misalign=%0d want 6 0", r_rd_cnt, r_misalign); end
    endtask

    task automatic test_n2();
        gen_dists(2); build_exp(2);
        do_run(2, -1, 0);
        checks++; if (!beats_match()) begin errors++; $display("FAIL n2_beats: got %p want %p", r_beats, exp_q); end
        checks++; if (r_last_cnt != 1 || r_last_pos != 1) begin errors++; $display("FAIL n2_last: got cnt=%0d pos=%0d want 1 1", r_last_cnt, r_last_pos); end
        checks++; if (r_max_sel != 1) begin errors++; $display("FAIL n2_sel: got max sel %0d want 1", r_max_sel); end
        checks++; if (r_done_cyc != exp_done(2, -1, 0)) begin errors++; $display("FAIL n2_done: got %0d want %0d", r_done_cyc, exp_done(2, -1, 0)); end
    endtask

    task automatic test_n0();
        do_run(0, -1, 0);
        checks++; if (r_done_cyc != 1) begin errors++; $display("FAIL n0_done: got cycle %0d want 1", r_done_cyc); end
        checks++; if (r_rd_cnt != 0 || r_rdy_cnt != 0) begin errors++; $display("FAIL n0_mem: got reads=%0d readies=%0d want 0 0", r_rd_cnt, r_rdy_cnt); end
        checks++; if (r_vld_cnt != 0) begin errors++; $display("FAIL n0_valid: got %0d valid cycles want 0", r_vld_cnt); end
    endtask

    task automatic test_backpressure();
        gen_dists(6); build_exp(6);
        do_run(6, 0, 5);
        checks++; if (r_stall_bad != 0) begin errors++; $display("FAIL bp_stable: got %0d changes during stall want 0", r_stall_bad); end
        checks++; if (!beats_match()) begin errors++; $display("FAIL bp_beats: got %p want %p", r_beats, exp_q); end
        checks++; if (r_done_cyc != exp_done(6, 0, 5)) begin errors++; $display("FAIL bp_done: got %0d want %0d", r_done_cyc, exp_done(6, 0, 5)); end
    endtask

    task automatic test_mid_reset();
        gen_dists(10);
        @(negedge clk); bus.start = 1'b1; bus.n_pts = AW'(10);
        @(negedge clk); bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.mem_rd_en !== 1'b0 || bus.sorter_ready !== 1'b0 || bus.res_valid !== 1'b0)
            begin errors++; $display("FAIL midrst_idle: got busy=%b rd=%b rdy=%b vld=%b want 0 0 0 0", bus.busy, bus.mem_rd_en, bus.sorter_ready, bus.res_valid); end
        gen_dists(5); build_exp(5);
        do_run(5, -1, 0);
        checks++; if (!beats_match()) begin errors++; $display("FAIL midrst_beats: got %p want %p", r_beats, exp_q); end
        checks++; if (r_rdy_first != 3 || r_rdy_cnt != 5 || r_done_cyc != exp_done(5, -1, 0))
            begin errors++; $display("FAIL midrst_timing: got first=%0d cnt=%0d done=%0d want 3 5 %0d", r_rdy_first, r_rdy_cnt, r_done_cyc, exp_done(5, -1, 0)); end
    endtask

    task automatic test_rst_start();
        @(negedge clk); rst = 1'b1; bus.start = 1'b1; bus.n_pts = AW'(5);
        @(negedge clk); rst = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_start: got busy=%b want 0", bus.busy); end
    endtask

    task automatic test_max();
        gen_dists(255); build_exp(255);
        do_run(255, -1, 0);
        checks++; if (!beats_match()) begin errors++; $display("FAIL max_beats: got %p want %p", r_beats, exp_q); end
        checks++; if (r_rd_cnt != 255 || r_rdy_cnt != 255 || r_rdy_last != 257)
            begin errors++; $display("FAIL max_counts: got reads=%0d readies=%0d last=%0d want 255 255 257", r_rd_cnt, r_rdy_cnt, r_rdy_last); end
        checks++; if (r_done_cyc != 262) begin errors++; $display("FAIL max_done: got %0d want 262", r_done_cyc); end
    endtask

    task automatic test_random();
        int n, sb, sl, no;
        for (int t = 0; t < 8; t++) begin
            n  = $urandom_range(1, 20);
            sb = $urandom_range(0, 4) - 1;
            sl = $urandom_range(0, 4);
            no = (n < K) ? n : K;
            gen_dists(n); build_exp(n);
            do_run(n, sb, sl);
            checks++; if (!beats_match()) begin errors++; $display("FAIL rand_beats n=%0d: got %p want %p", n, r_beats, exp_q); end
            checks++; if (r_last_cnt != 1 || r_last_pos != no - 1) begin errors++; $display("FAIL rand_last n=%0d: got cnt=%0d pos=%0d want 1 %0d", n, r_last_cnt, r_last_pos, no - 1); end
            checks++; if (r_done_cyc != exp_done(n, sb, sl) || r_rdy_cnt != n || r_stall_bad != 0)
                begin errors++; $display("FAIL rand_timing n=%0d: got done=%0d readies=%0d stallbad=%0d want %0d %0d 0", n, r_done_cyc, r_rdy_cnt, r_stall_bad, exp_done(n, sb, sl), n); end
        end
    endtask

    initial begin
        test_reset();
        test_vector6();
        test_n2();
        test_n0();
        test_backpressure();
        test_mid_reset();
        test_rst_start();
        test_max();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
